// File: rtl/seg_display_ctrl.sv
// rtl/seg_display_ctrl.sv - round-robin scheduler sharing a 4-digit seven-segment display among four 16-bit sources
module seg_display_ctrl #(
    parameter int DWELL = 25000000,
    parameter int CNT_W = 25,
    parameter bit LIVE  = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [15:0] val0,
    input  logic [15:0] val1,
    input  logic [15:0] val2,
    input  logic [15:0] val3,
    input  logic        hold,
    output logic [3:0]  in0,
    output logic [3:0]  in1,
    output logic [3:0]  in2,
    output logic [3:0]  in3,
    output logic [3:0]  grant,
    output logic [1:0]  active_src,
    output logic        blank
);

    typedef enum logic [1:0] {IDLE, SELECT, SHOW} state_t;

    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL - 1);

    state_t           state, state_d;
    logic [CNT_W-1:0] timer, timer_d;
    logic [1:0]       rr_ptr, rr_ptr_d;
    logic [15:0]      digits, digits_d;
    logic [3:0]       grant_d;
    logic [1:0]       src_d;
    logic             blank_d;

    logic [1:0]       winner;
    logic [1:0]       idx;
    logic             found;
    logic [15:0]      val_src;
    logic [15:0]      val_win;

    function automatic logic [15:0] pick(input logic [1:0] sel, input logic [15:0] a,
                                         input logic [15:0] b, input logic [15:0] c,
                                         input logic [15:0] d);
        logic [15:0] r;
        case (sel)
            2'd0:    r = a;
            2'd1:    r = b;
            2'd2:    r = c;
            default: r = d;
        endcase
        return r;
    endfunction

    // Scan starts just past the last winner; the last slot visited is rr_ptr itself,
    // so a lone requester re-wins every period.
    always_comb begin
        winner = rr_ptr;
        found  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= 4; i++) begin
            idx = rr_ptr + 2'(i);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign val_src = pick(active_src, val0, val1, val2, val3);
    assign val_win = pick(winner, val0, val1, val2, val3);

    always_comb begin
        state_d  = state;
        timer_d  = timer;
        rr_ptr_d = rr_ptr;
        digits_d = digits;
        grant_d  = grant;
        src_d    = active_src;
        blank_d  = blank;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_d = SELECT;
                end
            end
            SELECT: begin
                if (found) begin
                    state_d  = SHOW;
                    grant_d  = 4'b0001 << winner;
                    src_d    = winner;
                    digits_d = val_win;
                    blank_d  = 1'b0;
                    rr_ptr_d = winner;
                    timer_d  = DWELL_LOAD;
                end else begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    src_d    = '0;
                    digits_d = '0;
                    blank_d  = 1'b1;
                    timer_d  = '0;
                end
            end
            SHOW: begin
                if (LIVE) begin
                    digits_d = val_src;
                end
                if (timer != '0) begin
                    timer_d = timer - 1'b1;
                end
                // A dropped request ends the grant immediately; hold only stretches an expired dwell.
                if (!req[active_src] || ((timer == '0) && !hold)) begin
                    state_d = SELECT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            timer      <= '0;
            rr_ptr     <= 2'd3;
            digits     <= '0;
            grant      <= '0;
            active_src <= '0;
            blank      <= 1'b1;
        end else begin
            state      <= state_d;
            timer      <= timer_d;
            rr_ptr     <= rr_ptr_d;
            digits     <= digits_d;
            grant      <= grant_d;
            active_src <= src_d;
            blank      <= blank_d;
        end
    end

    assign in0 = digits[3:0];
    assign in1 = digits[7:4];
    assign in2 = digits[11:8];
    assign in3 = digits[15:12];

endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb/tb_seg_display_ctrl.sv - vector-table bench for seg_display_ctrl with DWELL=4, live and snapshot instances
module tb_seg_display_ctrl;

    localparam logic [15:0] V0 = 16'h12AF;
    localparam logic [15:0] V1 = 16'h3456;
    localparam logic [15:0] V2 = 16'h789A;
    localparam logic [15:0] V3 = 16'hBCDE;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req   = 4'h0;
    logic [15:0] val0  = V0;
    logic [15:0] val1  = V1;
    logic [15:0] val2  = V2;
    logic [15:0] val3  = V3;
    logic        hold  = 1'b0;

    logic [3:0]  a_in0, a_in1, a_in2, a_in3, a_grant;
    logic [1:0]  a_src;
    logic        a_blank;
    logic [3:0]  b_in0, b_in1, b_in2, b_in3, b_grant;
    logic [1:0]  b_src;
    logic        b_blank;

    seg_display_ctrl #(.DWELL(4), .CNT_W(3), .LIVE(1'b1)) dut_live (
        .clock(clock), .reset(reset), .req(req),
        .val0(val0), .val1(val1), .val2(val2), .val3(val3), .hold(hold),
        .in0(a_in0), .in1(a_in1), .in2(a_in2), .in3(a_in3),
        .grant(a_grant), .active_src(a_src), .blank(a_blank)
    );

    seg_display_ctrl #(.DWELL(4), .CNT_W(3), .LIVE(1'b0)) dut_snap (
        .clock(clock), .reset(reset), .req(req),
        .val0(val0), .val1(val1), .val2(val2), .val3(val3), .hold(hold),
        .in0(b_in0), .in1(b_in1), .in2(b_in2), .in3(b_in3),
        .grant(b_grant), .active_src(b_src), .blank(b_blank)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic        hold;
        logic [15:0] v0;
        logic        use_b;
        logic [3:0]  g;
        logic [1:0]  s;
        logic        bl;
        logic [15:0] d;
    } vec_t;

    vec_t tbl[$];
    vec_t snap[$];
    vec_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    function automatic vec_t mk(input logic rst, input logic [3:0] rq, input logic hl,
                                input logic [15:0] v0, input logic use_b, input logic [3:0] g,
                                input logic [1:0] s, input logic bl, input logic [15:0] d);
        vec_t v;
        v.rst = rst; v.req = rq; v.hold = hl; v.v0 = v0; v.use_b = use_b;
        v.g = g; v.s = s; v.bl = bl; v.d = d;
        return v;
    endfunction

    task automatic idle(input logic rst, input logic [3:0] rq, input logic [15:0] v0);
        tbl.push_back(mk(rst, rq, 1'b0, v0, 1'b0, 4'h0, 2'd0, 1'b1, 16'h0000));
    endtask

    task automatic shw(input int n, input logic [3:0] rq, input logic hl, input logic [15:0] v0,
                       input logic [1:0] s, input logic [15:0] d);
        for (int k = 0; k < n; k++)
            tbl.push_back(mk(1'b1, rq, hl, v0, 1'b0, 4'b0001 << s, s, 1'b0, d));
    endtask

    task automatic apply(input vec_t v, input int n);
        vec_t e;
        logic [3:0]  g;
        logic [1:0]  s;
        logic        bl;
        logic [15:0] d;
        reset = v.rst;
        req   = v.req;
        hold  = v.hold;
        val0  = v.v0;
        exp_q.push_back(v);
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        if (e.use_b) begin
            g = b_grant; s = b_src; bl = b_blank; d = {b_in3, b_in2, b_in1, b_in0};
        end else begin
            g = a_grant; s = a_src; bl = a_blank; d = {a_in3, a_in2, a_in1, a_in0};
        end
        compared++;
        if (g !== e.g || s !== e.s || bl !== e.bl || d !== e.d) begin
            mismatched++;
            $display("FAIL vec%0d%s: got grant=%b src=%0d blank=%b digits=%h, want grant=%b src=%0d blank=%b digits=%h",
                     n, e.use_b ? "(snap)" : "", g, s, bl, d, e.g, e.s, e.bl, e.d);
        end
    endtask

    initial begin
        // reset held with all requests, then released: source 0 wins first
        idle(1'b0, 4'hF, V0); idle(1'b0, 4'hF, V0);
        idle(1'b1, 4'hF, V0);
        shw(1, 4'hF, 1'b0, V0, 2'd0, V0);

        // single source re-wins every period; live digits follow val0 change
        idle(1'b0, 4'h1, V0); idle(1'b1, 4'h1, V0);
        shw(6, 4'h1, 1'b0, V0, 2'd0, V0);
        shw(2, 4'h1, 1'b0, 16'h0F0F, 2'd0, 16'h0F0F);

        // round robin over 1011: 0,1,3,0 each for 5 cycles, then reset mid-show
        idle(1'b0, 4'hB, V0); idle(1'b1, 4'hB, V0);
        shw(5, 4'hB, 1'b0, V0, 2'd0, V0);
        shw(5, 4'hB, 1'b0, V0, 2'd1, V1);
        shw(5, 4'hB, 1'b0, V0, 2'd3, V3);
        shw(1, 4'hB, 1'b0, V0, 2'd0, V0);
        idle(1'b0, 4'hB, V0);

        // hold keeps source 1 for 20 cycles; dropping req[1] moves on to source 3
        idle(1'b0, 4'hB, V0); idle(1'b1, 4'hB, V0);
        shw(5, 4'hB, 1'b0, V0, 2'd0, V0);
        shw(20, 4'hB, 1'b1, V0, 2'd1, V1);
        shw(1, 4'h9, 1'b1, V0, 2'd1, V1);
        shw(1, 4'h9, 1'b0, V0, 2'd3, V3);

        // all requests dropped in SHOW: SELECT then IDLE
        idle(1'b0, 4'h1, V0); idle(1'b1, 4'h1, V0);
        shw(2, 4'h1, 1'b0, V0, 2'd0, V0);
        shw(1, 4'h0, 1'b0, V0, 2'd0, V0);
        idle(1'b1, 4'h0, V0); idle(1'b1, 4'h0, V0);

        foreach (tbl[i]) apply(tbl[i], i);

        // snapshot instance keeps 00FF until the next SELECT exit
        snap.push_back(mk(1'b0, 4'h1, 1'b0, 16'h00FF, 1'b1, 4'h0, 2'd0, 1'b1, 16'h0000));
        snap.push_back(mk(1'b1, 4'h1, 1'b0, 16'h00FF, 1'b1, 4'h0, 2'd0, 1'b1, 16'h0000));
        snap.push_back(mk(1'b1, 4'h1, 1'b0, 16'h00FF, 1'b1, 4'h1, 2'd0, 1'b0, 16'h00FF));
        for (int k = 0; k < 4; k++)
            snap.push_back(mk(1'b1, 4'h1, 1'b0, 16'h1234, 1'b1, 4'h1, 2'd0, 1'b0, 16'h00FF));
        snap.push_back(mk(1'b1, 4'h1, 1'b0, 16'h1234, 1'b1, 4'h1, 2'd0, 1'b0, 16'h1234));
        snap.push_back(mk(1'b1, 4'h1, 1'b0, 16'h1234, 1'b1, 4'h1, 2'd0, 1'b0, 16'h1234));

        foreach (snap[i]) apply(snap[i], 1000 + i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
